icache_way_ctrl: RTL and testbench

- Direct-mapped read-only cache controller that drives a single cache way's write/read interface: the initiator side of the way's valid/tag/data storage.
- Accepts CPU fetch requests and looks up the way.
- On a miss, issues a line read to memory, collects 8 beats, writes valid/tag/line into the way, then returns the requested word.
- Sits between the CPU fetch port and the memory bus; the way itself is external.

---
 rtl/icache_way_ctrl_pkg.sv | 21 ++
 rtl/icache_way_ctrl_refill_buffer.sv | 32 +++
 rtl/icache_way_ctrl.sv | 141 ++++++++++++++
 tb/tb_icache_way_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_way_ctrl_pkg.sv
// Shared icache/dcache controller definitions: FSM encodings,
// line geometry and address slice positions.
package icache_way_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_WRITE,
    S_RESP
  } state_t;

  localparam int OFFSET_WIDTH   = 5;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_WIDTH     = 32;
  localparam int CNT_WIDTH      = 3;
  localparam int WORD_LSB       = 2;
  localparam int INDEX_LSB      = OFFSET_WIDTH;

endpackage

// File: rtl/icache_way_ctrl_refill_buffer.sv
// Refill line assembly: beat counter indexes an 8x32 buffer.
// clr restarts at word 0; beat_en stores beat_data; line = buffer.
import icache_way_ctrl_pkg::*;

module refill_buffer (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 beat_en,
  input  logic [WORD_WIDTH-1:0]                beat_data,
  output logic [WORDS_PER_LINE*WORD_WIDTH-1:0] line
);

  logic [CNT_WIDTH-1:0]                           cnt;
  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0]      line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      line_q <= '0;
    end else if (clr) begin
      cnt    <= '0;
      line_q <= '0;
    end else if (beat_en) begin
      line_q[cnt] <= beat_data;
      cnt         <= cnt + 1'b1;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/icache_way_ctrl.sv
// Direct-mapped read-only cache controller driving one external way.
// CPU fetch in/rsp out, memory line-read out/beats in, way r/w ports.
import icache_way_ctrl_pkg::*;

module icache_way_ctrl #(
  parameter int TARRAY_DATA_WIDTH = 24,
  parameter int DARRAY_DATA_WIDTH = 256,
  parameter int ADDR_WIDTH        = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         from_cpu_valid,
  input  logic [31:0]                  from_cpu_addr,
  output logic                         to_cpu_ready,
  output logic                         to_cpu_rsp_valid,
  output logic [31:0]                  to_cpu_rsp_data,
  input  logic                         from_cpu_rsp_ready,
  output logic                         to_mem_req_valid,
  output logic [31:0]                  to_mem_req_addr,
  input  logic                         from_mem_req_ready,
  input  logic                         from_mem_rvalid,
  input  logic [31:0]                  from_mem_rdata,
  input  logic                         from_mem_rlast,
  output logic                         to_mem_rready,
  output logic [ADDR_WIDTH-1:0]        way_waddr,
  output logic [ADDR_WIDTH-1:0]        way_raddr,
  output logic                         way_wen,
  output logic                         way_wvalid,
  output logic [TARRAY_DATA_WIDTH-1:0] way_wtag,
  output logic [DARRAY_DATA_WIDTH-1:0] way_wdata,
  input  logic                         way_rvalid,
  input  logic [TARRAY_DATA_WIDTH-1:0] way_rtag,
  input  logic [DARRAY_DATA_WIDTH-1:0] way_rdata
);

  localparam int TAG_LSB = 32 - TARRAY_DATA_WIDTH;

  state_t                         state, state_n;
  logic [31:0]                    req_addr;
  logic [31:0]                    rsp_q;
  logic [ADDR_WIDTH-1:0]          req_index;
  logic [TARRAY_DATA_WIDTH-1:0]   req_tag;
  logic [CNT_WIDTH-1:0]           word_sel;
  logic                           hit;
  logic                           buf_clr;
  logic                           beat_en;
  logic [DARRAY_DATA_WIDTH-1:0]   line_w;
  logic                           unused_addr_bits;

  assign req_index = req_addr[INDEX_LSB +: ADDR_WIDTH];
  assign req_tag   = req_addr[31:TAG_LSB];
  assign word_sel  = req_addr[WORD_LSB +: CNT_WIDTH];
  assign hit       = way_rvalid && (way_rtag == req_tag);
  assign unused_addr_bits = ^req_addr[1:0];

  assign way_raddr       = req_index;
  assign to_mem_req_addr = {req_addr[31:OFFSET_WIDTH],
                            {OFFSET_WIDTH{1'b0}}};
  assign to_cpu_rsp_data = rsp_q;

  refill_buffer u_refill_buffer (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .beat_en   (beat_en),
    .beat_data (from_mem_rdata),
    .line      (line_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      req_addr <= '0;
      rsp_q    <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && from_cpu_valid)
        req_addr <= from_cpu_addr;
      if (state == S_LOOKUP && hit)
        rsp_q <= way_rdata[WORD_WIDTH*word_sel +: WORD_WIDTH];
      if (state == S_WRITE)
        rsp_q <= line_w[WORD_WIDTH*word_sel +: WORD_WIDTH];
    end
  end

  always_comb begin
    state_n          = state;
    to_cpu_ready     = 1'b0;
    to_cpu_rsp_valid = 1'b0;
    to_mem_req_valid = 1'b0;
    to_mem_rready    = 1'b0;
    way_wen          = 1'b0;
    way_waddr        = '0;
    way_wvalid       = 1'b0;
    way_wtag         = '0;
    way_wdata        = '0;
    buf_clr          = 1'b0;
    beat_en          = 1'b0;
    unique case (state)
      S_IDLE: begin
        to_cpu_ready = 1'b1;
        if (from_cpu_valid)
          state_n = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_n = hit ? S_RESP : S_MISS_REQ;
      end
      S_MISS_REQ: begin
        to_mem_req_valid = 1'b1;
        if (from_mem_req_ready) begin
          buf_clr = 1'b1;
          state_n = S_REFILL;
        end
      end
      S_REFILL: begin
        to_mem_rready = 1'b1;
        if (from_mem_rvalid) begin
          beat_en = 1'b1;
          // rlast ends the burst; the counter only picks the slot
          if (from_mem_rlast)
            state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        way_wen    = 1'b1;
        way_waddr  = req_index;
        way_wvalid = 1'b1;
        way_wtag   = req_tag;
        way_wdata  = line_w;
        state_n    = S_RESP;
      end
      S_RESP: begin
        to_cpu_rsp_valid = 1'b1;
        if (from_cpu_rsp_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_way_ctrl.sv
// Bench for icache_way_ctrl: table of fetches against a way model,
// scoreboard of expected response words, reset-abort sequence.
module tb_icache_way_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         from_cpu_valid;
  logic [31:0]  from_cpu_addr;
  logic         to_cpu_ready;
  logic         to_cpu_rsp_valid;
  logic [31:0]  to_cpu_rsp_data;
  logic         from_cpu_rsp_ready;
  logic         to_mem_req_valid;
  logic [31:0]  to_mem_req_addr;
  logic         from_mem_req_ready;
  logic         from_mem_rvalid;
  logic [31:0]  from_mem_rdata;
  logic         from_mem_rlast;
  logic         to_mem_rready;
  logic [2:0]   way_waddr;
  logic [2:0]   way_raddr;
  logic         way_wen;
  logic         way_wvalid;
  logic [23:0]  way_wtag;
  logic [255:0] way_wdata;
  logic         way_rvalid;
  logic [23:0]  way_rtag;
  logic [255:0] way_rdata;

  icache_way_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .from_cpu_valid     (from_cpu_valid),
    .from_cpu_addr      (from_cpu_addr),
    .to_cpu_ready       (to_cpu_ready),
    .to_cpu_rsp_valid   (to_cpu_rsp_valid),
    .to_cpu_rsp_data    (to_cpu_rsp_data),
    .from_cpu_rsp_ready (from_cpu_rsp_ready),
    .to_mem_req_valid   (to_mem_req_valid),
    .to_mem_req_addr    (to_mem_req_addr),
    .from_mem_req_ready (from_mem_req_ready),
    .from_mem_rvalid    (from_mem_rvalid),
    .from_mem_rdata     (from_mem_rdata),
    .from_mem_rlast     (from_mem_rlast),
    .to_mem_rready      (to_mem_rready),
    .way_waddr          (way_waddr),
    .way_raddr          (way_raddr),
    .way_wen            (way_wen),
    .way_wvalid         (way_wvalid),
    .way_wtag           (way_wtag),
    .way_wdata          (way_wdata),
    .way_rvalid         (way_rvalid),
    .way_rtag           (way_rtag),
    .way_rdata          (way_rdata)
  );

  always #5 clk = ~clk;

  // way model: combinational read, write on wen, cleared by reset
  logic         wv [8];
  logic [23:0]  wt [8];
  logic [255:0] wd [8];
  int           wen_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        wv[i] <= 1'b0;
        wt[i] <= '0;
        wd[i] <= '0;
      end
    end else if (way_wen) begin
      wv[way_waddr] <= way_wvalid;
      wt[way_waddr] <= way_wtag;
      wd[way_waddr] <= way_wdata;
      wen_cnt       <= wen_cnt + 1;
    end
  end

  assign way_rvalid = wv[way_raddr];
  assign way_rtag   = wt[way_raddr];
  assign way_rdata  = wd[way_raddr];

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] base;
    logic [31:0] exp_data;
    int          req_stall;
    int          rsp_stall;
  } vec_t;

  vec_t vecs [9];

  task automatic accept(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    chk("cpu_ready_idle", to_cpu_ready, 1'b1);
    from_cpu_valid = 1'b1;
    from_cpu_addr  = a;
    exp_q.push_back(d);
    @(posedge clk);
    #1 from_cpu_valid = 1'b0;
    @(negedge clk);
    chk("lookup_no_rsp", to_cpu_rsp_valid, 1'b0);
  endtask

  task automatic mem_req(input logic [31:0] a, input int stall);
    int t;
    t = 0;
    while (!to_mem_req_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("mem_req_valid", to_mem_req_valid, 1'b1);
    chk("mem_req_addr", to_mem_req_addr, {a[31:5], 5'b0});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("req_valid_hold", to_mem_req_valid, 1'b1);
      chk("req_addr_hold", to_mem_req_addr, {a[31:5], 5'b0});
      chk("cpu_ready_busy", to_cpu_ready, 1'b0);
    end
    from_mem_req_ready = 1'b1;
    @(posedge clk);
    #1 from_mem_req_ready = 1'b0;
  endtask

  task automatic beats(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rready", to_mem_rready, 1'b1);
      from_mem_rvalid = 1'b1;
      from_mem_rdata  = base + k + 1;
      from_mem_rlast  = (k == 7);
      @(posedge clk);
      #1;
      from_mem_rvalid = 1'b0;
      from_mem_rlast  = 1'b0;
    end
  endtask

  task automatic fetch(input vec_t v);
    logic [255:0] line;
    logic [31:0]  want;
    int           w0;
    w0 = wen_cnt;
    accept(v.addr, v.exp_data);
    if (v.miss) begin
      mem_req(v.addr, v.req_stall);
      beats(v.base, 8);
      for (int k = 0; k < 8; k++) line[32*k +: 32] = v.base + k + 1;
      @(negedge clk);
      chk("way_wen", way_wen, 1'b1);
      chk("way_waddr", way_waddr, v.addr[7:5]);
      chk("way_wvalid", way_wvalid, 1'b1);
      chk("way_wtag", way_wtag, v.addr[31:8]);
      chk("way_wdata", way_wdata, line);
    end else begin
      chk("hit_no_memreq", to_mem_req_valid, 1'b0);
    end
    @(negedge clk);
    chk("rsp_valid", to_cpu_rsp_valid, 1'b1);
    chk("rsp_no_memreq", to_mem_req_valid, 1'b0);
    for (int i = 0; i < v.rsp_stall; i++) begin
      chk("rsp_data_hold", to_cpu_rsp_data, v.exp_data);
      chk("cpu_ready_resp", to_cpu_ready, 1'b0);
      @(negedge clk);
      chk("rsp_valid_hold", to_cpu_rsp_valid, 1'b1);
    end
    want = exp_q.pop_front();
    chk("rsp_data", to_cpu_rsp_data, want);
    from_cpu_rsp_ready = 1'b1;
    @(posedge clk);
    #1 from_cpu_rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_done", to_cpu_rsp_valid, 1'b0);
    chk("wen_pulses", wen_cnt - w0, v.miss ? 1 : 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_cpu_ready", to_cpu_ready, 1'b1);
    chk("rst_req_valid", to_mem_req_valid, 1'b0);
    chk("rst_req_addr", to_mem_req_addr, 32'h0);
    chk("rst_rready", to_mem_rready, 1'b0);
    chk("rst_rsp_valid", to_cpu_rsp_valid, 1'b0);
    chk("rst_rsp_data", to_cpu_rsp_data, 32'h0);
    chk("rst_wen", way_wen, 1'b0);
    chk("rst_wdata", way_wdata, 256'h0);
  endtask

  initial begin
    int w0;
    vec_t v;
    rst                = 1'b1;
    wen_cnt            = 0;
    from_cpu_valid     = 1'b0;
    from_cpu_addr      = '0;
    from_cpu_rsp_ready = 1'b0;
    from_mem_req_ready = 1'b0;
    from_mem_rvalid    = 1'b0;
    from_mem_rdata     = '0;
    from_mem_rlast     = 1'b0;

    vecs[0] = '{32'h0000_0040, 1'b1, 32'h0,    32'h1,    0, 0};
    vecs[1] = '{32'h0000_0044, 1'b0, 32'h0,    32'h2,    0, 0};
    vecs[2] = '{32'h0000_0144, 1'b1, 32'h100,  32'h102,  0, 0};
    vecs[3] = '{32'h0000_0140, 1'b0, 32'h0,    32'h101,  0, 0};
    vecs[4] = '{32'h0000_0044, 1'b1, 32'h200,  32'h202,  5, 3};
    vecs[5] = '{32'hABCD_E0E8, 1'b1, 32'h5000, 32'h5003, 0, 0};
    vecs[6] = '{32'hABCD_E0FC, 1'b0, 32'h0,    32'h5008, 0, 0};
    vecs[7] = '{32'h0000_001C, 1'b1, 32'h300,  32'h308,  0, 0};
    vecs[8] = '{32'h0000_0010, 1'b0, 32'h0,    32'h305,  0, 0};

    #12;
    chk_reset_outs();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) fetch(vecs[i]);

    // abort a refill after four beats with reset
    w0 = wen_cnt;
    accept(32'h0000_0240, 32'h0);
    mem_req(32'h0000_0240, 0);
    beats(32'h700, 4);
    @(negedge clk);
    rst = 1'b1;
    from_mem_rvalid = 1'b1;
    from_mem_rdata  = 32'h705;
    #1;
    chk_reset_outs();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 5; k < 8; k++) begin
      from_mem_rdata = 32'h700 + k + 1;
      from_mem_rlast = (k == 7);
      @(negedge clk);
      chk("abort_rready", to_mem_rready, 1'b0);
    end
    from_mem_rvalid = 1'b0;
    from_mem_rlast  = 1'b0;
    chk("abort_no_wen", wen_cnt - w0, 0);

    v = '{32'h0000_0240, 1'b1, 32'h800, 32'h801, 0, 0};
    fetch(v);
    v = '{32'h0000_025C, 1'b0, 32'h0,   32'h808, 0, 2};
    fetch(v);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
